// File: rtl/keypad_fifo_ctrl_if.sv
// Handshake bundle between the keypad encoder/consumer and the FIFO controller.
// The overflow member only exists when KFC_OVERFLOW_EN is defined.
interface keypad_fifo_ctrl_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  v;
  logic                  read;
  logic                  wr_enable;
  logic                  rd_enable;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  valid;
`ifdef KFC_OVERFLOW_EN
  logic                  overflow;
`endif

  modport master (
`ifdef KFC_OVERFLOW_EN
    output overflow,
`endif
    input  v, read,
    output wr_enable, rd_enable, wr_addr, rd_addr, count,
    output full, empty, almost_full, valid
  );

  modport slave (
`ifdef KFC_OVERFLOW_EN
    input  overflow,
`endif
    output v, read,
    input  wr_enable, rd_enable, wr_addr, rd_addr, count,
    input  full, empty, almost_full, valid
  );
endinterface

// File: rtl/keypad_fifo_ctrl.sv
// Pointer/occupancy controller for a keypad FIFO backed by a synchronous RAM.
// Define KFC_OVERFLOW_EN to add the sticky overflow flag for dropped writes.
module keypad_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int EDGE_MODE  = 1,
  parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 2
) (
  input logic                clock,
  input logic                reset,
  keypad_fifo_ctrl_if.master bus
);
  localparam logic [DEPTH_LOG2:0]   FullCnt = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   AfCnt   = (DEPTH_LOG2+1)'(AF_LEVEL);
  localparam logic [DEPTH_LOG2:0]   CntOne  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);

  typedef enum logic {IDLE, HELD} edgeState_e;

  edgeState_e            state_q, state_d;
  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2-1:0] wrAddr_q, rdAddr_q;
  logic                  wrEnable_q, rdEnable_q, valid_q;
  logic                  full_q, empty_q, almostFull_q;
  logic                  wrReq, rdAcc, wrAcc, dropWr;

  // A held key stays in HELD until released, so it produces only one write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.v)  state_d = HELD;
      HELD: if (!bus.v) state_d = IDLE;
    endcase
  end

  always_comb begin
    wrReq   = (EDGE_MODE != 0) ? (bus.v && (state_q == IDLE)) : bus.v;
    rdAcc   = bus.read && !empty_q;
    wrAcc   = wrReq && (!full_q || rdAcc);
    dropWr  = wrReq && full_q && !rdAcc;
    wrPtr_d = wrAcc ? wrPtr_q + PtrOne : wrPtr_q;
    rdPtr_d = rdAcc ? rdPtr_q + PtrOne : rdPtr_q;
    count_d = count_q;
    unique case ({wrAcc, rdAcc})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Flags come from count_d so they line up with the registered count.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      wrAddr_q     <= '0;
      rdAddr_q     <= '0;
      wrEnable_q   <= 1'b0;
      rdEnable_q   <= 1'b0;
      valid_q      <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      almostFull_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      wrEnable_q   <= wrAcc;
      rdEnable_q   <= rdAcc;
      valid_q      <= rdEnable_q;
      full_q       <= (count_d == FullCnt);
      empty_q      <= (count_d == '0);
      almostFull_q <= (count_d >= AfCnt);
      if (wrAcc) wrAddr_q <= wrPtr_q;
      if (rdAcc) rdAddr_q <= rdPtr_q;
    end
  end

`ifdef KFC_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clock) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_q || dropWr;
  end

  assign bus.overflow = overflow_q;
`else
  logic unusedDrop;
  assign unusedDrop = dropWr;
`endif

  assign bus.wr_enable   = wrEnable_q;
  assign bus.rd_enable   = rdEnable_q;
  assign bus.wr_addr     = wrAddr_q;
  assign bus.rd_addr     = rdAddr_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.almost_full = almostFull_q;
  assign bus.valid       = valid_q;
endmodule

// File: tb/tb_keypad_fifo_ctrl.sv
// Scoreboard bench: an edge-mode and a level-mode controller share one stimulus
// stream and are compared against a queue-based occupancy model.
module tb_keypad_fifo_ctrl;
  localparam int DepthLog2 = 2;
  localparam int Depth     = 1 << DepthLog2;
  localparam int AfLevel   = 2;

  typedef struct {
    bit wrEn, rdEn, valid, full, empty, af, ovf;
    int count, wrAddr, rdAddr;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  keypad_fifo_ctrl_if #(.DEPTH_LOG2(DepthLog2)) busA ();
  keypad_fifo_ctrl_if #(.DEPTH_LOG2(DepthLog2)) busB ();

  keypad_fifo_ctrl #(.DEPTH_LOG2(DepthLog2), .EDGE_MODE(1), .AF_LEVEL(AfLevel)) dutEdge (
    .clock(clock), .reset(reset), .bus(busA)
  );
  keypad_fifo_ctrl #(.DEPTH_LOG2(DepthLog2), .EDGE_MODE(0), .AF_LEVEL(AfLevel)) dutLevel (
    .clock(clock), .reset(reset), .bus(busB)
  );

  int checks = 0;
  int passes = 0;

  exp_t expQA[$];
  exp_t expQB[$];

  // Reference model: index 0 is edge mode, index 1 is level mode.
  int mCount[2];
  int mWrPtr[2];
  int mRdPtr[2];
  bit mPrevV[2];
  bit mRdPrev[2];
  bit mOvf[2];

  function automatic exp_t modelStep(int m, bit v, bit rd, bit rst);
    exp_t e;
    bit wreq, rdOk, wrOk;
    e = '{default: 0};
    if (rst) begin
      mCount[m] = 0; mWrPtr[m] = 0; mRdPtr[m] = 0;
      mPrevV[m] = 0; mRdPrev[m] = 0; mOvf[m] = 0;
    end else begin
      wreq = (m == 0) ? (v && !mPrevV[m]) : v;
      mPrevV[m] = v;
      rdOk = rd && (mCount[m] > 0);
      wrOk = wreq && ((mCount[m] < Depth) || rdOk);
      if (wreq && !wrOk) mOvf[m] = 1;
      e.valid = mRdPrev[m];
      mRdPrev[m] = rdOk;
      e.wrEn = wrOk;
      e.rdEn = rdOk;
      e.wrAddr = mWrPtr[m];
      e.rdAddr = mRdPtr[m];
      if (wrOk) begin mWrPtr[m] = (mWrPtr[m] + 1) % Depth; mCount[m]++; end
      if (rdOk) begin mRdPtr[m] = (mRdPtr[m] + 1) % Depth; mCount[m]--; end
    end
    e.count = mCount[m];
    e.full  = (mCount[m] == Depth);
    e.empty = (mCount[m] == 0);
    e.af    = (mCount[m] >= AfLevel);
    e.ovf   = mOvf[m];
    return e;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic checkSet(string tag, exp_t e, bit wrEn, bit rdEn, bit vld, bit full, bit empty,
                          bit af, bit ovf, int cnt, int wa, int ra);
    checkOutput({tag, ".count"}, cnt, e.count);
    checkOutput({tag, ".full"}, int'(full), int'(e.full));
    checkOutput({tag, ".empty"}, int'(empty), int'(e.empty));
    checkOutput({tag, ".almost_full"}, int'(af), int'(e.af));
    checkOutput({tag, ".wr_enable"}, int'(wrEn), int'(e.wrEn));
    checkOutput({tag, ".rd_enable"}, int'(rdEn), int'(e.rdEn));
    checkOutput({tag, ".valid"}, int'(vld), int'(e.valid));
    if (wrEn && e.wrEn) checkOutput({tag, ".wr_addr"}, wa, e.wrAddr);
    if (rdEn && e.rdEn) checkOutput({tag, ".rd_addr"}, ra, e.rdAddr);
`ifdef KFC_OVERFLOW_EN
    checkOutput({tag, ".overflow"}, int'(ovf), int'(e.ovf));
`else
    if (ovf) checkOutput({tag, ".overflow"}, 1, 0);
`endif
  endtask

  // Monitor: outputs are sampled on the falling edge, before the driver moves.
  always @(negedge clock) begin
    exp_t e;
    bit ovfA, ovfB;
`ifdef KFC_OVERFLOW_EN
    ovfA = busA.overflow;
    ovfB = busB.overflow;
`else
    ovfA = 1'b0;
    ovfB = 1'b0;
`endif
    if (expQA.size() > 0) begin
      e = expQA.pop_front();
      checkSet("edge", e, busA.wr_enable, busA.rd_enable, busA.valid, busA.full, busA.empty,
               busA.almost_full, ovfA, int'(busA.count), int'(busA.wr_addr), int'(busA.rd_addr));
    end
    if (expQB.size() > 0) begin
      e = expQB.pop_front();
      checkSet("level", e, busB.wr_enable, busB.rd_enable, busB.valid, busB.full, busB.empty,
               busB.almost_full, ovfB, int'(busB.count), int'(busB.wr_addr), int'(busB.rd_addr));
    end
  end

  task automatic applyStimulus(bit v, bit rd, bit rst);
    @(negedge clock);
    #1;
    reset = rst;
    busA.v = v; busA.read = rd;
    busB.v = v; busB.read = rd;
    expQA.push_back(modelStep(0, v, rd, rst));
    expQB.push_back(modelStep(1, v, rd, rst));
  endtask

  initial begin
    reset = 1'b1;
    busA.v = 1'b0; busA.read = 1'b0;
    busB.v = 1'b0; busB.read = 1'b0;

    applyStimulus(0, 0, 1);
    applyStimulus(1, 1, 1);

    // Single pulse, held key, separate second pulse.
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 1);
    repeat (5) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);

    // Fill past capacity, then simultaneous write and read on a full FIFO.
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
    end
    applyStimulus(1, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);

    // Read while empty, then v held for three cycles.
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    repeat (3) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);

    // Reset right after an accepted read must squash the pending valid.
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);

    // Reset released with v already high still accepts one write in edge mode.
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 49) == 0));
    end

    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    #1;
    checkOutput("queueDrained", expQA.size() + expQB.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
